// File: rtl/median3_stream_filter.sv
// Streaming median-of-3 filter: sliding window over a valid/ready sample stream, one job of NUM_SAMPLES inputs per start.
// Optional edge replication (first/last sample passed through) when MEDIAN3_STREAM_FILTER_EDGE_REPLICATE_EN is defined.
module median3_stream_filter #(
    parameter int WIDTH       = 32,
    parameter int NUM_SAMPLES = 8533,
    parameter bit SIGNED      = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(NUM_SAMPLES + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] LAST_IN  = CNT_W'(NUM_SAMPLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_RUN,
        S_DRAIN,
        S_DONE
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] in_cnt;
    logic [CNT_W-1:0] out_cnt;
    // The oldest window slot is shifted out before it is ever needed: the median on
    // each Accept uses the two newest stored samples plus the incoming one.
    logic [WIDTH-1:0] w1;
    logic [WIDTH-1:0] w2;
    logic             accept;
    logic             emit;

    function automatic logic less(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (SIGNED) return $signed(a) < $signed(b);
        else        return a < b;
    endfunction

    // median = max(min(a,b), min(max(a,b),c))
    function automatic logic [WIDTH-1:0] med3(input logic [WIDTH-1:0] a,
                                              input logic [WIDTH-1:0] b,
                                              input logic [WIDTH-1:0] c);
        logic [WIDTH-1:0] lo;
        logic [WIDTH-1:0] hi;
        logic [WIDTH-1:0] mid;
        lo  = less(a, b) ? a : b;
        hi  = less(a, b) ? b : a;
        mid = less(hi, c) ? hi : c;
        return less(lo, mid) ? mid : lo;
    endfunction

    assign in_ready = ((state == S_FILL) || (state == S_RUN)) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign emit     = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            in_cnt    <= '0;
            out_cnt   <= '0;
            w1        <= '0;
            w2        <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            // NOTE: these default updates come first; a later non-blocking assignment
            // to the same register in the case below wins, so a new result replaces
            // the one being emitted in the same cycle without a bubble.
            if (emit) begin
                out_valid <= 1'b0;
                out_cnt   <= out_cnt + CNT_ONE;
            end
            if (accept) begin
                w1     <= w2;
                w2     <= in_data;
                in_cnt <= in_cnt + CNT_ONE;
            end

            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state   <= S_FILL;
                        in_cnt  <= '0;
                        out_cnt <= '0;
                        w1      <= '0;
                        w2      <= '0;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                S_FILL: begin
                    if (accept) begin
`ifdef MEDIAN3_STREAM_FILTER_EDGE_REPLICATE_EN
                        if (in_cnt == '0) begin
                            out_data  <= in_data;
                            out_valid <= 1'b1;
                        end
`endif
                        if (in_cnt == CNT_ONE) state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        out_data  <= med3(w1, w2, in_data);
                        out_valid <= 1'b1;
                        if (in_cnt == LAST_IN) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    if (emit) begin
`ifdef MEDIAN3_STREAM_FILTER_EDGE_REPLICATE_EN
                        // The last sample is replayed as the final output once the last median leaves.
                        if (out_cnt == LAST_IN) begin
                            state <= S_DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            out_data  <= w2;
                            out_valid <= 1'b1;
                        end
`else
                        state <= S_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
`endif
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_median3_stream_filter.sv
// Self-checking bench for median3_stream_filter: scoreboard of expected medians per job,
// plus signedness, backpressure, restart and mid-job reset scenarios.
module tb_median3_stream_filter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // Main instance: WIDTH=8, NUM_SAMPLES=5, unsigned
    logic       start5, iv5, ir5, ov5, or5, busy5, done5;
    logic [7:0] id5, od5;

    median3_stream_filter #(.WIDTH(8), .NUM_SAMPLES(5), .SIGNED(1'b0)) u_d5 (
        .clk(clk), .rst(rst), .start(start5),
        .in_valid(iv5), .in_ready(ir5), .in_data(id5),
        .out_valid(ov5), .out_ready(or5), .out_data(od5),
        .busy(busy5), .done(done5)
    );

    // Signedness pair: NUM_SAMPLES=3, same stimulus, unsigned vs signed compare
    logic       start3, iv3, or3;
    logic       ir3u, ov3u, b3u, d3u;
    logic       ir3s, ov3s, b3s, d3s;
    logic [7:0] id3, od3u, od3s;

    median3_stream_filter #(.WIDTH(8), .NUM_SAMPLES(3), .SIGNED(1'b0)) u_d3u (
        .clk(clk), .rst(rst), .start(start3),
        .in_valid(iv3), .in_ready(ir3u), .in_data(id3),
        .out_valid(ov3u), .out_ready(or3), .out_data(od3u),
        .busy(b3u), .done(d3u)
    );

    median3_stream_filter #(.WIDTH(8), .NUM_SAMPLES(3), .SIGNED(1'b1)) u_d3s (
        .clk(clk), .rst(rst), .start(start3),
        .in_valid(iv3), .in_ready(ir3s), .in_data(id3),
        .out_valid(ov3s), .out_ready(or3), .out_data(od3s),
        .busy(b3s), .done(d3s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Reference median by sorting three values
    function automatic logic [7:0] ref_med(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        logic [7:0] t;
        if (a > b) begin t = a; a = b; b = t; end
        if (b > c) begin t = b; b = c; c = t; end
        if (a > b) begin t = a; a = b; b = t; end
        return b;
    endfunction

    logic [7:0] exp_q[$];
    bit         done_pending = 1'b0;

    function automatic void push_job(input logic [7:0] x[5]);
`ifdef MEDIAN3_STREAM_FILTER_EDGE_REPLICATE_EN
        exp_q.push_back(x[0]);
`endif
        for (int i = 1; i <= 3; i++) exp_q.push_back(ref_med(x[i-1], x[i], x[i+1]));
`ifdef MEDIAN3_STREAM_FILTER_EDGE_REPLICATE_EN
        exp_q.push_back(x[4]);
`endif
    endfunction

    // Scoreboard monitor: every Emit pops one expected value; done must follow the last Emit by one cycle.
    always @(negedge clk) begin
        if (!rst) begin
            if (done_pending) begin
                check("done_after_last_emit", done5, 1);
                done_pending = 1'b0;
            end
            if (ov5 && or5) begin
                if (exp_q.size() == 0) begin
                    check("expected_results_left_on_emit", 32'(exp_q.size()), 1);
                end else begin
                    check("out_data", od5, exp_q.pop_front());
                    if (exp_q.size() == 0) done_pending = 1'b1;
                end
            end
        end
    end

    task automatic send5(input logic [7:0] x, output int waited);
        iv5 = 1'b1;
        id5 = x;
        waited = 0;
        @(negedge clk);
        while (!ir5 && waited < 50) begin
            waited++;
            @(negedge clk);
        end
        if (!ir5) check("send_timeout_cycles", waited, 0);
        @(posedge clk); #1;
        iv5 = 1'b0;
        id5 = 8'($urandom);
    endtask

    task automatic start_job5(input logic [7:0] x[5]);
        push_job(x);
        start5 = 1'b1;
        @(posedge clk); #1;
        start5 = 1'b0;
        check("busy_after_start", busy5, 1);
        check("done_cleared_by_start", done5, 0);
    endtask

    task automatic wait_done5();
        int c = 0;
        while (!done5 && c < 100) begin
            @(negedge clk);
            c++;
        end
        check("job_reaches_done", done5, 1);
        check("scoreboard_drained", 32'(exp_q.size()), 0);
        check("busy_low_in_done", busy5, 0);
        @(posedge clk); #1;
    endtask

    task automatic feed3(input logic [7:0] x, input int idx);
        iv3 = 1'b1;
        id3 = x;
        @(negedge clk);
        check($sformatf("sign_in_ready_u_%0d", idx), ir3u, 1);
        check($sformatf("sign_in_ready_s_%0d", idx), ir3s, 1);
        @(posedge clk); #1;
        iv3 = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] basic[5];
        logic [7:0] again[5];
        int w;
        int c;

        basic = '{8'd5, 8'd1, 8'd9, 8'd3, 8'd7};
        again = '{8'd2, 8'd2, 8'd8, 8'd8, 8'd1};

        rst = 1'b1;
        start5 = 1'b0; iv5 = 1'b0; id5 = 8'h00; or5 = 1'b1;
        start3 = 1'b0; iv3 = 1'b0; id3 = 8'h00; or3 = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready",  ir5, 0);
        check("rst_out_valid", ov5, 0);
        check("rst_out_data",  od5, 0);
        check("rst_busy",      busy5, 0);
        check("rst_done",      done5, 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check("idle_in_ready", ir5, 0);

        // Signedness: 0xFF, 0x01, 0x80
        start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        feed3(8'hFF, 0);
        feed3(8'h01, 1);
        feed3(8'h80, 2);
        check("sign_out_valid_u", ov3u, 1);
        check("sign_unsigned_median", od3u, 8'h80);
        check("sign_out_valid_s", ov3s, 1);
        check("sign_signed_median", od3s, 8'hFF);
        c = 0;
        while (!(d3u && d3s) && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("sign_done_u", d3u, 1);
        check("sign_done_s", d3s, 1);
        @(posedge clk); #1;

        // Basic run, full throughput
        start_job5(basic);
        for (int i = 0; i < 5; i++) begin
            send5(basic[i], w);
            check($sformatf("basic_no_wait_%0d", i), w, 0);
            if (i == 2) check("basic_latency_one_cycle", ov5, 1);
        end
        wait_done5();

        // Backpressure: out_ready low for 4 cycles after the first out_valid
        start_job5(basic);
        fork
            begin
                int k = 0;
                while (!ov5 && k < 50) begin
                    @(posedge clk); #1;
                    k++;
                end
                check("bp_first_valid_seen", ov5, 1);
                or5 = 1'b0;
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    check($sformatf("bp_valid_held_%0d", s), ov5, 1);
                    check($sformatf("bp_data_held_%0d", s), od5, 5);
                    check($sformatf("bp_in_ready_low_%0d", s), ir5, 0);
                    @(posedge clk); #1;
                end
                or5 = 1'b1;
            end
        join_none
        for (int i = 0; i < 5; i++) send5(basic[i], w);
        wait_done5();
        wait fork;

        // Start pulsed in RUN is ignored; then restart from DONE with a new sequence
        start_job5(basic);
        for (int i = 0; i < 5; i++) begin
            if (i == 3) start5 = 1'b1;
            send5(basic[i], w);
            start5 = 1'b0;
            if (i == 3) check("start_in_run_ignored_busy", busy5, 1);
        end
        check("done_set_before_restart_wait", 32'(exp_q.size() <= 1), 1);
        wait_done5();
        check("done_held_in_done", done5, 1);
        start_job5(again);
        for (int i = 0; i < 5; i++) send5(again[i], w);
        wait_done5();

        // Reset mid-job after Accept 3 with a result pending
        start_job5(basic);
        for (int i = 0; i < 3; i++) send5(basic[i], w);
        check("mid_rst_result_pending", ov5, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_q.delete();
        done_pending = 1'b0;
        check("mid_rst_out_valid", ov5, 0);
        check("mid_rst_busy", busy5, 0);
        check("mid_rst_done", done5, 0);
        check("mid_rst_in_ready", ir5, 0);
        check("mid_rst_out_data", od5, 0);

        // Fresh job after reset matches the basic run
        start_job5(basic);
        for (int i = 0; i < 5; i++) send5(basic[i], w);
        wait_done5();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
